// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesting masters and the round-robin arbiter.
interface rr_grant_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic           lock;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  modport master (
    output req,
    output lock,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  preempt
  );

  modport slave (
    input  req,
    input  lock,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output preempt
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter for N requesters with bounded hold time under
// contention, an owner lock that freezes the hold counter, and a one-cycle
// preempt pulse after a forced revoke. Every ownership change passes through
// one IDLE cycle with no grant.
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  rr_grant_arbiter_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]  HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
  localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [N-1:0]   gnt_q, gnt_n;
  logic [IDW-1:0] id_q, id_n;
  logic           pre_q, pre_n;

  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] owner_next;
  logic           contention;

  // Find the first requester at or after the priority pointer, wrapping mod N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  // Next-state, pointer, hold counter and grant outputs for IDLE/BUSY.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cnt_n      = cnt;
    gnt_n      = gnt_q;
    id_n       = id_q;
    pre_n      = 1'b0;
    owner_next = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
    contention = |(bus.req & ~gnt_q);

    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          gnt_n   = ONE_HOT0 << pick;
          id_n    = pick;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (!bus.req[id_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
          ptr_n   = owner_next;
        end else if ((MAX_HOLD != 0) && contention && !bus.lock && (cnt == HOLD_LAST)) begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
          ptr_n   = owner_next;
          pre_n   = 1'b1;
        end else if ((MAX_HOLD != 0) && contention && !bus.lock) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        id_n    = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt_q <= '0;
      id_q  <= '0;
      pre_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt_q <= gnt_n;
      id_q  <= id_n;
      pre_q <= pre_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.preempt   = pre_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with N=4, MAX_HOLD=8.
module tb_rr_grant_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rr_grant_arbiter_if #(.N(4)) bus ();

  rr_grant_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive request and lock inputs.
  task automatic applyStimulus(input logic [3:0] r, input logic l);
    bus.req  = r;
    bus.lock = l;
  endtask

  // Compare {gnt, gnt_id, gnt_valid, preempt} against expected values.
  task automatic checkOutput(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                             input logic ev, input logic ep);
    logic [7:0] obs, exp;
    obs = {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt};
    exp = {eg, eid, ev, ep};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed gnt/id/valid/pre=%b required %b", tag, obs, exp);
    end
  endtask

  // Hold the grant for n more cycles, checking it stays put.
  task automatic holdGrant(input string tag, input int n, input logic [3:0] eg, input logic [1:0] eid);
    for (int c = 0; c < n; c++) begin
      tick();
      checkOutput(tag, eg, eid, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] g;
    applyStimulus(4'b0000, 1'b0);
    tick();
    tick();
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single request grant and release.
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("release0", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Full contention rotation from a fresh pointer.
    reset = 1'b1;
    #2;
    checkOutput("reset_pulse", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      tick();
      checkOutput("rot_grant", g, 2'(k % 4), 1'b1, 1'b0);
      holdGrant("rot_hold", 7, g, 2'(k % 4));
      if (k < 4) begin
        tick();
        checkOutput("rot_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
      end
    end
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("rot_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 1 releases early with requester 3 pending.
    applyStimulus(4'b1010, 1'b0);
    tick();
    checkOutput("own1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    holdGrant("own1_hold", 2, 4'b0010, 2'd1);
    applyStimulus(4'b1000, 1'b0);
    tick();
    checkOutput("own1_release_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("own3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Owner 3 releases; pointer wraps to 0 so requester 0 beats 3.
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("own3_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    tick();
    checkOutput("wrap_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("wrap_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Lock holds owner 0 under contention; unlocking resumes the count.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b0011, 1'b1);
    tick();
    checkOutput("lock_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    holdGrant("lock_hold", 20, 4'b0001, 2'd0);
    applyStimulus(4'b0011, 1'b0);
    holdGrant("unlock_hold", 7, 4'b0001, 2'd0);
    tick();
    checkOutput("unlock_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("unlock_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Move ownership to requester 2, then reset asynchronously mid-grant.
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("to2_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("own2_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0110, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("post_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Release coinciding with the preemption point: release wins.
    holdGrant("coinc_hold", 7, 4'b0010, 2'd1);
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("coinc_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("coinc_next", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Registered round-robin arbiter sharing one resource (bus or datapath port) among `N` requesters. It extends the two-requester `req_0`/`req_1` → `gnt_0`/`gnt_1` grant controller style to `N` requesters with three additions: rotating priority, a bounded hold time under contention, and an owner lock. It sits between the requesting masters and the shared resource and drives a one-hot grant plus an encoded owner index.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `MAX_HOLD`, default 8: maximum number of contended cycles an owner may keep the grant; 0 disables preemption.
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately.
- `req`  in  N  request vector; bit i is requester i.
- `lock`  in  1  when high, the current owner cannot be preempted.
- `gnt`  out  N  one-hot grant, registered; all-zero when no owner.
- `gnt_valid`  out  1  high when any `gnt` bit is high.
- `gnt_id`  out  $clog2(N)  index of the current owner; 0 when `gnt_valid`=0.
- `preempt`  out  1  one-cycle pulse in the cycle after a forced revoke.

## Operation
- Reset values:
  - Outputs: `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempt`=0.
  - Internal: state IDLE, priority pointer `ptr`=0, hold counter `cnt`=0.
- States: IDLE (no owner) and BUSY (owner = `gnt_id`).
- IDLE, at a clock edge:
  - If `req`≠0, select the first set bit searching `ptr`, `ptr`+1, …, wrapping mod N.
  - Load `gnt`, `gnt_id` and `gnt_valid`, clear `cnt`, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: contention is defined as `(req & ~gnt) != 0`. At each clock edge, the first matching rule below applies:
  1. `req[owner]`=0 → release. Clear `gnt`, set `ptr`=owner+1 mod N, go to IDLE, keep `preempt`=0.
  2. `MAX_HOLD`≠0, contention, `lock`=0 and `cnt`==`MAX_HOLD`−1 → preempt. Clear `gnt`, set `ptr`=owner+1 mod N, drive `preempt`=1, go to IDLE.
  3. Contention and `lock`=0 → `cnt`++.
  4. Otherwise → `cnt` holds.
- Hold counter:
  - Counts only contended, unlocked cycles.
  - It is not cleared when contention disappears; it is cleared only on a new grant.
- Counter width: $clog2(`MAX_HOLD`+1). It never wraps, because preemption occurs before overflow.
- `preempt` is registered. It is high only during the single IDLE cycle that follows a preemption and is cleared at the next edge.
- `gnt` is always one-hot or zero. `gnt_id` and `gnt_valid` always agree with `gnt`.
- Requests from non-owners never affect `gnt` while BUSY, except through preemption.

## Timing
- Grant latency:
  - `req` is sampled at edge k while in IDLE; `gnt` is high from edge k (visible in cycle k+1).
  - Minimum latency from request to grant: 1 cycle.
- Release latency: `req[owner]` sampled low at edge k → `gnt`=0 in cycle k+1.
- Gap: every ownership change has at least one IDLE cycle with `gnt`=0. Back-to-back owners are therefore separated by exactly one idle cycle when the next request is already pending.
- Preemption:
  - Under continuous contention with `lock`=0, the owner holds `gnt` for exactly `MAX_HOLD` cycles.
  - Then one IDLE cycle follows with `preempt`=1.
  - Then the next requester in round-robin order is granted.
- Lock: raising `lock` stalls `cnt`. Lowering it resumes counting from the retained value.
- Preemption of a requester that keeps `req` high: that requester re-enters arbitration at the lowest priority (`ptr` has moved past it).
- Simultaneous release and preemption condition: release wins and `preempt` stays 0.
- `lock` while IDLE: ignored.
- Async reset mid-grant: `gnt` and all outputs go to 0 immediately, without waiting for a clock edge. After reset deassertion, the first edge arbitrates from `ptr`=0.

## Test plan
- Reset, then `req`=0001 → `gnt`=0001, `gnt_id`=0 one cycle later. Drop `req` → `gnt`=0 the next cycle.
- `N`=4, `MAX_HOLD`=8, `req`=1111 held, `lock`=0:
  - Grants rotate 0→1→2→3→0.
  - Each grant is 8 cycles long, followed by a 1-cycle gap with `preempt`=1.
- Owner 1 drops `req` after 3 cycles with `req`[3] pending → `gnt`=0 for one cycle with `preempt`=0, then `gnt`=1000.
- `req`=0011, owner 0, `lock`=1 for 20 cycles → `gnt`=0001 throughout, `preempt` never asserts. Lower `lock` → preempt after 8 more contended cycles; `gnt`=0010 follows.
- Pointer wrap: owner 3 releases with `req`=1001 → next `gnt`=0001, `gnt_id`=0.
- Assert `reset` asynchronously mid-grant with `gnt`=0100 → all outputs 0 before the next edge. After release with `req`=0110 → `gnt`=0010.
